uart_rx_os: RTL and testbench
=============================

// Module: uart_rx_os
// PURPOSE
//   Parametrised oversampling UART receiver; next generation of the fixed 8-bit receiver.
//   Adds: 2-FF input sync, a baud divider, 3-sample majority vote, start-bit glitch reject,
//   runtime parity and stop-bit config, and a valid/ready output with overrun detection.
//   Sits between the async RX_data pin and any byte consumer (FIFO, bus bridge).
// PARAMETERS
//   WIDTH            8   data bits per frame, legal 5..9, sent LSB first
//   OVERSAMPLE       16  sample ticks per bit, even, >=8
//   CLKS_PER_SAMPLE  54  clk cycles per sample tick (100 MHz / 115200 / 16)
// PORTS
//   clk             in   1      system clock
//   rst             in   1      synchronous reset, active-high
//   RX_data         in   1      async serial line, idles high
//   cfg_parity      in   2      00/11 none, 01 even, 10 odd; latched at start-bit confirm
//   cfg_stop2       in   1      1 = two stop bits; latched at start-bit confirm
//   rx_ready        in   1      consumer accepts rx_data_out when rx_valid&&rx_ready
//   rx_data_out     out  WIDTH  received data word
//   rx_valid        out  1      holding register full
//   parity_bit_err  out  1      parity mismatch for the held word; qualified by rx_valid
//   stop_bit_err    out  1      a stop sample was 0 for the held word; qualified by rx_valid
//   overrun_err     out  1      1-cycle pulse: a frame completed while the register was full
//   busy            out  1      FSM not in IDLE
// BEHAVIOUR
//   - Reset: all outputs 0, FSM=IDLE, sync flops=1, divider and counters=0. Reset mid-frame
//     aborts the frame; the held word is discarded.
//   - Divider: tick every CLKS_PER_SAMPLE clks; it restarts on the start edge so the phase is aligned.
//   - Majority: each bit is the vote of the samples at ticks OS/2-1, OS/2 and OS/2+1 of that bit.
//   - FSM states and transitions:
//     IDLE   -> START  on a synced 1->0 edge.
//     START  -> DATA   if the vote at mid-start is 0; config is latched here.
//     START  -> IDLE   if the vote is 1 (glitch); no flags are raised.
//     DATA   -> PARITY after WIDTH bits if parity is enabled; otherwise DATA -> STOP.
//     PARITY -> STOP.  STOP -> STOP2 if cfg_stop2; otherwise STOP -> DONE.  STOP2 -> DONE.
//     DONE   -> IDLE   after 1 clk.
//   - Stop bits: the mid-bit sample ends the stop state; no wait to the bit end, which
//     tolerates +/-0.5 bit of accumulated drift.
//   - Parity: even = XOR(data)^p must be 0; odd = it must be 1. With none, parity_bit_err=0.
//   - Output:
//     * In DONE with rx_valid=0, load rx_data_out and the error flags; rx_valid=1 next clk.
//     * Latency from the mid-sample of the last stop bit to rx_valid is 2 clks.
//     * rx_valid stays high until the handshake; the word and flags are stable meanwhile.
//     * Handshake and a new DONE in the same clk: accept the old word, load the new one.
//   - Overrun: DONE with rx_valid=1 and no handshake drops the new frame and pulses
//     overrun_err for 1 clk; the held word is kept.
//   - Framing error: the word is still delivered with stop_bit_err=1. IDLE re-arms only
//     after the line is seen high, so a held-low line yields no further frames.
// CONFIGURATION
//   UART_RX_BREAK_DETECT_EN
//     Defined: a frame with all data bits 0, parity 0 and stop 0 is a break.
//       - Port break_det (out, 1) pulses 1 clk and the frame is not delivered.
//       - busy stays high until the line returns high.
//     Undefined: no break_det port; the frame is delivered as 0 with stop_bit_err=1.
// TESTING  (WIDTH=8, OVERSAMPLE=16, CLKS_PER_SAMPLE=4 -> 64 clk/bit)
//   1. 0xA5, no parity, 1 stop, rx_ready=1 -> rx_valid 1 clk, data 0xA5, both errs 0.
//   2. 0x3C, even parity, parity bit 1 -> data 0x3C, parity_bit_err=1. Same frame with odd
//      parity -> parity_bit_err=0.
//   3. Low glitch of 20 clks on the idle line -> back to IDLE, no rx_valid, no error.
//   4. rx_ready=0, send 0x11 then 0x22 -> 0x11 is held, overrun_err pulses once. Then raise
//      rx_ready -> 0x11 is accepted and rx_valid falls.
//   5. 0x55 with stop sample 0 -> stop_bit_err=1 with data 0x55. With cfg_stop2=1 and the
//      2nd stop low -> stop_bit_err=1.
//   6. Assert rst mid-data -> next clk busy=0, rx_valid=0. A following 0x81 is received
//      correctly. Line held low 12 bits with the macro defined -> break_det pulses once,
//      no rx_valid.

Source files
------------

// File: rtl/uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_os
// Description : Oversampling UART receiver.
//               - 2-FF synchroniser on the async RX_data line
//               - baud divider re-phased on the start edge
//               - 3-sample majority vote around the middle of each bit
//               - start-bit glitch rejection
//               - runtime parity (none/even/odd) and 1/2 stop bits
//               - valid/ready holding register with overrun pulse
// Parameters  : WIDTH (5..9 data bits, LSB first), OVERSAMPLE (ticks per bit,
//               even, >=8), CLKS_PER_SAMPLE (clk cycles per sample tick)
// Ports       : clk, rst (sync, active-high), RX_data (idles high),
//               cfg_parity[1:0] (00/11 none, 01 even, 10 odd), cfg_stop2,
//               rx_ready -> rx_data_out[WIDTH-1:0], rx_valid, parity_bit_err,
//               stop_bit_err, overrun_err (1-clk pulse), busy
// Option      : UART_RX_BREAK_DETECT_EN adds output break_det; an all-zero
//               frame with a low stop bit is then reported as a break and
//               not delivered, and busy holds until the line returns high.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_os #(
    parameter int WIDTH           = 8,
    parameter int OVERSAMPLE      = 16,
    parameter int CLKS_PER_SAMPLE = 54
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RX_data,
    input  logic [1:0]       cfg_parity,
    input  logic             cfg_stop2,
    input  logic             rx_ready,
    output logic [WIDTH-1:0] rx_data_out,
    output logic             rx_valid,
    output logic             parity_bit_err,
    output logic             stop_bit_err,
    output logic             overrun_err,
    output logic             busy
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    output logic             break_det
`endif
);

    localparam int c_DIV_W = (CLKS_PER_SAMPLE > 1) ? $clog2(CLKS_PER_SAMPLE) : 1;
    localparam int c_OS_W  = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(WIDTH);

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLKS_PER_SAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_OS_LAST  = c_OS_W'(OVERSAMPLE - 1);
    localparam logic [c_OS_W-1:0]  c_S0       = c_OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OS_W-1:0]  c_S1       = c_OS_W'(OVERSAMPLE / 2);
    localparam logic [c_OS_W-1:0]  c_S2       = c_OS_W'(OVERSAMPLE / 2 + 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WIDTH - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;
    localparam logic [2:0] c_STOP2  = 3'd5;
    localparam logic [2:0] c_DONE   = 3'd6;
`ifdef UART_RX_BREAK_DETECT_EN
    localparam logic [2:0] c_BRKW   = 3'd7;
`endif

    logic               r_sync1, r_sync2, r_line_prev;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [c_OS_W-1:0]  r_os_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic               r_s0, r_s1;
    logic [WIDTH-1:0]   r_shift;
    logic               r_par_bit;
    logic [1:0]         r_par_mode;
    logic               r_stop2;
    logic               r_stop_err;
    logic [2:0]         r_state;
    logic [2:0]         w_next_state;
    logic               w_busy;

    logic w_tick, w_vote_tick, w_vote, w_fall, w_par_en, w_par_err;
    logic w_accept, w_is_break, w_done_frame;

    assign w_tick      = (r_div_cnt == c_DIV_LAST);
    assign w_vote_tick = w_tick && (r_os_cnt == c_S2);
    // Third sample is the live synced line at the last voting tick
    assign w_vote      = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);
    assign w_fall      = r_line_prev & ~r_sync2;
    assign w_par_en    = (r_par_mode == 2'b01) || (r_par_mode == 2'b10);
    // Even: XOR of data and parity must be 0; odd: it must be 1
    assign w_par_err   = w_par_en && ((^r_shift ^ r_par_bit) != (r_par_mode == 2'b10));
    assign w_accept    = rx_valid && rx_ready;
`ifdef UART_RX_BREAK_DETECT_EN
    assign w_is_break  = (r_shift == '0) && !r_par_bit && r_stop_err;
`else
    assign w_is_break  = 1'b0;
`endif
    assign w_done_frame = (r_state == c_DONE) && !w_is_break;
    assign busy         = w_busy;

    // ---------------- FSM state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_next_state;
    end

    // ---------------- FSM next state / outputs ----------------
    always_comb begin
        w_next_state = r_state;
        w_busy       = (r_state != c_IDLE);
        case (r_state)
            c_IDLE:   if (w_fall) w_next_state = c_START;
            c_START:  if (w_vote_tick) w_next_state = w_vote ? c_IDLE : c_DATA;
            c_DATA:   if (w_vote_tick && (r_bit_cnt == c_BIT_LAST))
                          w_next_state = w_par_en ? c_PARITY : c_STOP;
            c_PARITY: if (w_vote_tick) w_next_state = c_STOP;
            // Stop ends at its mid-bit vote, not at the bit end, to absorb drift
            c_STOP:   if (w_vote_tick) w_next_state = r_stop2 ? c_STOP2 : c_DONE;
            c_STOP2:  if (w_vote_tick) w_next_state = c_DONE;
`ifdef UART_RX_BREAK_DETECT_EN
            c_DONE:   w_next_state = w_is_break ? c_BRKW : c_IDLE;
            c_BRKW:   if (r_sync2) w_next_state = c_IDLE;
`else
            c_DONE:   w_next_state = c_IDLE;
`endif
            default:  w_next_state = c_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1        <= 1'b1;
            r_sync2        <= 1'b1;
            r_line_prev    <= 1'b1;
            r_div_cnt      <= '0;
            r_os_cnt       <= '0;
            r_bit_cnt      <= '0;
            r_s0           <= 1'b0;
            r_s1           <= 1'b0;
            r_shift        <= '0;
            r_par_bit      <= 1'b0;
            r_par_mode     <= 2'b00;
            r_stop2        <= 1'b0;
            r_stop_err     <= 1'b0;
            rx_data_out    <= '0;
            rx_valid       <= 1'b0;
            parity_bit_err <= 1'b0;
            stop_bit_err   <= 1'b0;
            overrun_err    <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_det      <= 1'b0;
`endif
        end else begin
            r_sync1     <= RX_data;
            r_sync2     <= r_sync1;
            r_line_prev <= r_sync2;

            // Divider restarts on the start edge so ticks are phase-aligned to the frame
            if (((r_state == c_IDLE) && w_fall) || w_tick) r_div_cnt <= '0;
            else                                           r_div_cnt <= r_div_cnt + 1'b1;

            if (r_state == c_IDLE)  r_os_cnt <= '0;
            else if (w_tick)        r_os_cnt <= (r_os_cnt == c_OS_LAST) ? '0 : r_os_cnt + 1'b1;

            if (w_tick && (r_os_cnt == c_S0)) r_s0 <= r_sync2;
            if (w_tick && (r_os_cnt == c_S1)) r_s1 <= r_sync2;

            if (w_vote_tick) begin
                case (r_state)
                    c_START: if (!w_vote) begin
                        r_par_mode <= cfg_parity;
                        r_stop2    <= cfg_stop2;
                        r_bit_cnt  <= '0;
                        r_par_bit  <= 1'b0;
                        r_stop_err <= 1'b0;
                    end
                    c_DATA: begin
                        r_shift   <= {w_vote, r_shift[WIDTH-1:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    c_PARITY: r_par_bit <= w_vote;
                    c_STOP, c_STOP2: if (!w_vote) r_stop_err <= 1'b1;
                    default: ;
                endcase
            end

            overrun_err <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
            break_det   <= (r_state == c_DONE) && w_is_break;
`endif
            // A handshake in the same clk as a new frame frees the register for it
            if (w_done_frame) begin
                if (!rx_valid || w_accept) begin
                    rx_data_out    <= r_shift;
                    parity_bit_err <= w_par_err;
                    stop_bit_err   <= r_stop_err;
                    rx_valid       <= 1'b1;
                end else begin
                    overrun_err    <= 1'b1;
                end
            end else if (w_accept) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_os.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_os
// Description : Self-checking bench for uart_rx_os (WIDTH=8, OVERSAMPLE=16,
//               CLKS_PER_SAMPLE=4 -> 64 clk per bit). Frames from a vector
//               table push expected words to a queue; a monitor pops and
//               compares on every rx_valid/rx_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_os;

    localparam int c_BIT_CLKS = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_data;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       rx_ready;
    logic [7:0] rx_data_out;
    logic       rx_valid, parity_bit_err, stop_bit_err, overrun_err, busy;
`ifdef UART_RX_BREAK_DETECT_EN
    logic       break_det;
`endif

    uart_rx_os #(.WIDTH(8), .OVERSAMPLE(16), .CLKS_PER_SAMPLE(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .RX_data        (RX_data),
        .cfg_parity     (cfg_parity),
        .cfg_stop2      (cfg_stop2),
        .rx_ready       (rx_ready),
        .rx_data_out    (rx_data_out),
        .rx_valid       (rx_valid),
        .parity_bit_err (parity_bit_err),
        .stop_bit_err   (stop_bit_err),
        .overrun_err    (overrun_err),
`ifdef UART_RX_BREAK_DETECT_EN
        .busy           (busy),
        .break_det      (break_det)
`else
        .busy           (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        logic [1:0] par;
        logic       stop2;
        logic       pbit;
        logic       s1;
        logic       s2;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_serr;
    } vec_t;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       se;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   ov_cnt = 0;
    int   brk_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Scoreboard monitor: every handshake consumes one expected word
    always @(negedge clk) begin
        if (!rst && rx_valid && rx_ready) begin
            if (q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", rx_data_out, $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("rx_data_out", 32'(rx_data_out), 32'(e.d));
                check("parity_bit_err", 32'(parity_bit_err), 32'(e.pe));
                check("stop_bit_err", 32'(stop_bit_err), 32'(e.se));
            end
        end
        if (overrun_err) ov_cnt++;
`ifdef UART_RX_BREAK_DETECT_EN
        if (break_det) brk_cnt++;
`endif
    end

    task automatic drive_bit(input logic b);
        @(negedge clk);
        RX_data = b;
        repeat (c_BIT_CLKS - 1) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] par, input logic st2,
                              input logic pbit, input logic s1, input logic s2);
        cfg_parity = par;
        cfg_stop2  = st2;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        if (par == 2'b01 || par == 2'b10) drive_bit(pbit);
        drive_bit(s1);
        if (st2) drive_bit(s2);
        drive_bit(1'b1);
        drive_bit(1'b1);
    endtask

    task automatic push(input logic [7:0] d, input logic pe, input logic se);
        exp_t e;
        e.d = d; e.pe = pe; e.se = se;
        q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    vec_t vecs[9];

    initial begin
        //        data   par    st2   pbit  s1    s2    exp    perr  serr
        vecs[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 2'b01, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
        vecs[3] = '{8'h55, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1};
        vecs[4] = '{8'h55, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 8'h55, 1'b0, 1'b1};
        vecs[5] = '{8'h81, 2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
        vecs[6] = '{8'h00, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[8] = '{8'h80, 2'b01, 1'b1, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

        rst = 1'b1; RX_data = 1'b1; cfg_parity = 2'b00; cfg_stop2 = 1'b0; rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_data", 32'(rx_data_out), 32'd0);
        check("reset_errs", {29'd0, parity_bit_err, stop_bit_err, overrun_err}, 32'd0);
        repeat (20) @(negedge clk);

        // Table-driven frames
        for (int i = 0; i < 9; i++) begin
            push(vecs[i].exp_data, vecs[i].exp_perr, vecs[i].exp_serr);
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stop2, vecs[i].pbit, vecs[i].s1, vecs[i].s2);
        end
        check("table_queue_drained", 32'(q.size()), 32'd0);

        // Start-bit glitch of 20 clks
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        @(negedge clk) RX_data = 1'b0;
        repeat (10) @(negedge clk);
        check("glitch_busy_during", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        RX_data = 1'b1;
        repeat (2 * c_BIT_CLKS) @(negedge clk);
        check("glitch_busy_after", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);

        // Overrun: 0x11 held, 0x22 dropped
        @(posedge clk); #1 rx_ready = 1'b0;
        ov_cnt = 0;
        push(8'h11, 1'b0, 1'b0);
        send_frame(8'h11, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("overrun_pulses", 32'(ov_cnt), 32'd1);
        check("overrun_valid_held", 32'(rx_valid), 32'd1);
        check("overrun_word_held", 32'(rx_data_out), 32'h11);
        @(posedge clk); #1 rx_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("overrun_valid_falls", 32'(rx_valid), 32'd0);
        check("overrun_queue", 32'(q.size()), 32'd0);

        // Reset mid-data discards a held word and aborts the frame
        @(posedge clk); #1 rx_ready = 1'b0;
        send_frame(8'h33, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("prereset_valid", 32'(rx_valid), 32'd1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        drive_bit(1'b1);
        check("prereset_busy", 32'(busy), 32'd1);
        @(negedge clk);
        rst = 1'b1; RX_data = 1'b1;
        @(negedge clk);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(rx_valid), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1 rx_ready = 1'b1;
        repeat (2 * c_BIT_CLKS) @(negedge clk);
        push(8'h81, 1'b0, 1'b0);
        send_frame(8'h81, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("post_reset_queue", 32'(q.size()), 32'd0);

        // Line held low for 12 bit times
        cfg_parity = 2'b00; cfg_stop2 = 1'b0;
        brk_cnt = 0;
`ifndef UART_RX_BREAK_DETECT_EN
        push(8'h00, 1'b0, 1'b1);
`endif
        @(negedge clk) RX_data = 1'b0;
        repeat (12 * c_BIT_CLKS) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_busy_low", 32'(busy), 32'd1);
`else
        check("lowline_no_rearm", 32'(busy), 32'd0);
`endif
        RX_data = 1'b1;
        repeat (2 * c_BIT_CLKS) @(negedge clk);
        check("lowline_busy_after", 32'(busy), 32'd0);
        check("lowline_queue", 32'(q.size()), 32'd0);
`ifdef UART_RX_BREAK_DETECT_EN
        check("break_pulses", 32'(brk_cnt), 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
